// File: rtl/mem_arbiter.sv
// Frame-buffer arbiter: one display port (V) with absolute priority and two
// scaler ports (R read, W write) sharing a single-port RAM with one-cycle
// read latency. Scaler ports alternate through a 1-bit round-robin pointer.
module mem_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    // display read port
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    // scaler session enable
    input  logic              scl_en,
    // scaler read port
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_rvalid,
    // scaler write port
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    // shared read data
    output logic [DATA_W-1:0] rdata,
    // RAM side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata,
    // statistics
    output logic [15:0]       conflict_cnt
);

    typedef enum logic {
        PTR_R = 1'b0,
        PTR_W = 1'b1
    } ptr_t;

    ptr_t              ptr_reg;
    ptr_t              ptr_next;
    logic              conflict_next;
    logic [15:0]       conflict_cnt_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              mem_wren_reg;

    // Read-tag pipeline: stage 0 holds grants of the previous cycle, stage 1
    // lines up with the RAM output. Owner bit is 1 for port R, 0 for port V.
    logic [1:0]        tag_valid_reg;
    logic [1:0]        tag_owner_reg;
    logic [1:0]        tag_valid_in;
    logic [1:0]        tag_owner_in;

    // Pointer register: the only piece of arbitration state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= PTR_R;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // Grant decode, pointer advance and conflict detection; grants forced low in reset.
    always_comb begin
        vga_gnt       = 1'b0;
        rd_gnt        = 1'b0;
        wr_gnt        = 1'b0;
        ptr_next      = ptr_reg;
        conflict_next = 1'b0;
        if (!reset) begin
            if (vga_req) begin
                vga_gnt = 1'b1;
            end else if (scl_en) begin
                if (rd_req && wr_req) begin
                    if (ptr_reg == PTR_R) begin
                        rd_gnt = 1'b1;
                    end else begin
                        wr_gnt = 1'b1;
                    end
                end else if (rd_req) begin
                    rd_gnt = 1'b1;
                end else if (wr_req) begin
                    wr_gnt = 1'b1;
                end
            end
            // A scaler grant hands the next tie to the other scaler port.
            if (rd_gnt) begin
                ptr_next = PTR_W;
            end else if (wr_gnt) begin
                ptr_next = PTR_R;
            end
            // Only eligible (scl_en) scaler requests can be denied.
            conflict_next = scl_en && ((rd_req && !rd_gnt) || (wr_req && !wr_gnt));
        end
    end

    // Saturating count of cycles with at least one denied scaler request.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt_reg <= 16'h0000;
        end else if (conflict_next && (conflict_cnt_reg != 16'hFFFF)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 16'h0001;
        end
    end

    // RAM command register: address/data hold their last value when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wren_reg  <= 1'b0;
        end else begin
            mem_wren_reg <= wr_gnt;
            if (vga_gnt) begin
                mem_addr_reg <= vga_addr;
            end else if (rd_gnt) begin
                mem_addr_reg <= rd_addr;
            end else if (wr_gnt) begin
                mem_addr_reg  <= wr_addr;
                mem_wdata_reg <= wr_data;
            end
        end
    end

    assign tag_valid_in = {tag_valid_reg[0], vga_gnt | rd_gnt};
    assign tag_owner_in = {tag_owner_reg[0], rd_gnt};

    // One register per tag stage; reset discards any read still in flight.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (reset) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_owner_reg[gi] <= 1'b0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_in[gi];
                    tag_owner_reg[gi] <= tag_owner_in[gi];
                end
            end
        end
    endgenerate

    assign vga_rvalid   = tag_valid_reg[1] & ~tag_owner_reg[1];
    assign rd_rvalid    = tag_valid_reg[1] &  tag_owner_reg[1];
    assign rdata        = mem_rdata;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign mem_wren     = mem_wren_reg;
    assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM
// (registered address, one-cycle read latency). RAM preload: ram[a] = a[7:0] ^ 8'h3C.
module tb_mem_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic              scl_en;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_rvalid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       conflict_cnt;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
        .scl_en(scl_en),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    // behavioural RAM
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic idle_inputs();
        vga_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        vga_addr = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; scl_en = 1'b1;
        vga_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        vga_addr = 17'h00001; rd_addr = 17'h00002; wr_addr = 17'h00003; wr_data = 8'h77;
        @(negedge clk); #1;
        total++; if (vga_gnt !== 1'b0) begin bad++; $display("FAIL reset_vga_gnt: got %b want 0", vga_gnt); end
        total++; if (rd_gnt !== 1'b0) begin bad++; $display("FAIL reset_rd_gnt: got %b want 0", rd_gnt); end
        total++; if (wr_gnt !== 1'b0) begin bad++; $display("FAIL reset_wr_gnt: got %b want 0", wr_gnt); end
        @(negedge clk); #1;
        total++; if (mem_addr !== 17'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        total++; if (mem_wdata !== 8'h0) begin bad++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        total++; if (mem_wren !== 1'b0) begin bad++; $display("FAIL reset_mem_wren: got %b want 0", mem_wren); end
        total++; if (conflict_cnt !== 16'h0) begin bad++; $display("FAIL reset_conflict_cnt: got %0d want 0", conflict_cnt); end
        total++; if ({vga_rvalid, rd_rvalid} !== 2'b00) begin bad++; $display("FAIL reset_rvalid: got %b want 00", {vga_rvalid, rd_rvalid}); end
        idle_inputs();
        reset = 1'b0;
        $display("test_reset: reset state checked");
    endtask

    task automatic test_vga_only();
        @(negedge clk);
        vga_req = 1'b1; vga_addr = 17'h00010;
        #1;
        $display("txn vga read addr=%h", vga_addr);
        total++; if ({vga_gnt, rd_gnt, wr_gnt} !== 3'b100) begin bad++; $display("FAIL vga_only_gnt: got %b want 100", {vga_gnt, rd_gnt, wr_gnt}); end
        @(negedge clk);
        idle_inputs(); #1;
        total++; if (mem_addr !== 17'h00010) begin bad++; $display("FAIL vga_only_mem_addr: got %h want 00010", mem_addr); end
        total++; if (vga_rvalid !== 1'b0) begin bad++; $display("FAIL vga_only_early_rvalid: got %b want 0", vga_rvalid); end
        @(negedge clk); #1;
        total++; if ({vga_rvalid, rd_rvalid} !== 2'b10) begin bad++; $display("FAIL vga_only_rvalid: got %b want 10", {vga_rvalid, rd_rvalid}); end
        total++; if (rdata !== 8'h2C) begin bad++; $display("FAIL vga_only_rdata: got %h want 2c", rdata); end
        @(negedge clk); #1;
        total++; if (vga_rvalid !== 1'b0) begin bad++; $display("FAIL vga_only_rvalid_drop: got %b want 0", vga_rvalid); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_rd [4] = '{8'h1C, 8'h1D, 8'h1E, 8'h1F};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 4) begin
                vga_req = 1'b1; vga_addr = 17'h00020 + 17'(i);
            end else begin
                idle_inputs();
            end
            #1;
            $display("txn b2b cycle %0d vga_gnt=%b vga_rvalid=%b rdata=%h", i, vga_gnt, vga_rvalid, rdata);
            if (i >= 2) begin
                total++; if (vga_rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rvalid[%0d]: got %b want 1", i, vga_rvalid); end
                total++; if (rdata !== exp_rd[i-2]) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rdata, exp_rd[i-2]); end
            end
        end
    endtask

    task automatic test_contention();
        do_reset();
        scl_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vga_req = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
            vga_addr = 17'h00030; rd_addr = 17'h00031; wr_addr = 17'h00032; wr_data = 8'h11;
            #1;
            $display("txn contention cycle %0d gnt v/r/w=%b", i, {vga_gnt, rd_gnt, wr_gnt});
            total++; if ({vga_gnt, rd_gnt, wr_gnt} !== 3'b100) begin bad++; $display("FAIL contention_gnt[%0d]: got %b want 100", i, {vga_gnt, rd_gnt, wr_gnt}); end
        end
        @(negedge clk);
        vga_req = 1'b0;
        #1;
        total++; if (conflict_cnt !== 16'd3) begin bad++; $display("FAIL contention_cnt: got %0d want 3", conflict_cnt); end
        total++; if ({rd_gnt, wr_gnt} !== 2'b10) begin bad++; $display("FAIL contention_ptr: got r/w=%b want 10", {rd_gnt, wr_gnt}); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic exp_wren;
        logic exp_rv;
        do_reset();
        scl_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 6) begin
                rd_req = 1'b1; rd_addr = 17'h00100 + 17'(i);
                wr_req = 1'b1; wr_addr = 17'h00200 + 17'(i); wr_data = 8'h50 + 8'(i);
            end else begin
                idle_inputs();
            end
            #1;
            $display("txn rr cycle %0d gnt r/w=%b mem_wren=%b rd_rvalid=%b", i, {rd_gnt, wr_gnt}, mem_wren, rd_rvalid);
            if (i < 6) begin
                total++; if ({rd_gnt, wr_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, {rd_gnt, wr_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01); end
            end
            exp_wren = (i >= 1) && (i <= 6) && ((i - 1) % 2 == 1);
            total++; if (mem_wren !== exp_wren) begin bad++; $display("FAIL rr_wren[%0d]: got %b want %b", i, mem_wren, exp_wren); end
            if (exp_wren) begin
                total++; if (mem_wdata !== 8'h50 + 8'(i - 1)) begin bad++; $display("FAIL rr_wdata[%0d]: got %h want %h", i, mem_wdata, 8'h50 + 8'(i - 1)); end
            end
            exp_rv = (i >= 2) && ((i - 2) % 2 == 0);
            total++; if (rd_rvalid !== exp_rv) begin bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, rd_rvalid, exp_rv); end
            if (exp_rv) begin
                total++; if (rdata !== (8'(i - 2) ^ 8'h3C)) begin bad++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, rdata, 8'(i - 2) ^ 8'h3C); end
            end
        end
        total++; if (conflict_cnt !== 16'd6) begin bad++; $display("FAIL rr_cnt: got %0d want 6", conflict_cnt); end
    endtask

    task automatic test_gating();
        do_reset();
        scl_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rd_req = 1'b1; rd_addr = 17'h00300; wr_req = 1'b1; wr_addr = 17'h00301; wr_data = 8'hEE;
            #1;
            total++; if ({rd_gnt, wr_gnt, mem_wren} !== 3'b000) begin bad++; $display("FAIL gating[%0d]: got r/w/wren=%b want 000", i, {rd_gnt, wr_gnt, mem_wren}); end
        end
        @(negedge clk);
        idle_inputs(); #1;
        $display("txn gating done conflict_cnt=%0d", conflict_cnt);
        total++; if (conflict_cnt !== 16'd0) begin bad++; $display("FAIL gating_cnt: got %0d want 0", conflict_cnt); end
    endtask

    task automatic test_coherency();
        scl_en = 1'b1;
        @(negedge clk);
        wr_req = 1'b1; wr_addr = 17'h12C00; wr_data = 8'hA5;
        #1;
        total++; if ({rd_gnt, wr_gnt} !== 2'b01) begin bad++; $display("FAIL coh_wr_gnt: got %b want 01", {rd_gnt, wr_gnt}); end
        @(negedge clk);
        idle_inputs(); rd_req = 1'b1; rd_addr = 17'h12C00;
        #1;
        total++; if ({rd_gnt, wr_gnt} !== 2'b10) begin bad++; $display("FAIL coh_rd_gnt: got %b want 10", {rd_gnt, wr_gnt}); end
        total++; if ({mem_wren, mem_addr, mem_wdata} !== {1'b1, 17'h12C00, 8'hA5}) begin bad++; $display("FAIL coh_wr_cmd: got wren=%b addr=%h data=%h want 1/12c00/a5", mem_wren, mem_addr, mem_wdata); end
        @(negedge clk);
        idle_inputs(); #1;
        total++; if ({mem_wren, mem_addr} !== {1'b0, 17'h12C00}) begin bad++; $display("FAIL coh_rd_cmd: got wren=%b addr=%h want 0/12c00", mem_wren, mem_addr); end
        @(negedge clk); #1;
        $display("txn coherency rd_rvalid=%b rdata=%h", rd_rvalid, rdata);
        total++; if ({rd_rvalid, vga_rvalid} !== 2'b10) begin bad++; $display("FAIL coh_rvalid: got r/v=%b want 10", {rd_rvalid, vga_rvalid}); end
        total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL coh_rdata: got %h want a5", rdata); end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        scl_en = 1'b1;
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 17'h00040; wr_req = 1'b1; wr_addr = 17'h00041; wr_data = 8'h33;
        #1;
        total++; if ({rd_gnt, wr_gnt} !== 2'b10) begin bad++; $display("FAIL mid_first_gnt: got %b want 10", {rd_gnt, wr_gnt}); end
        @(negedge clk);
        wr_req = 1'b0; rd_addr = 17'h00042;
        #1;
        total++; if (rd_gnt !== 1'b1) begin bad++; $display("FAIL mid_rd_gnt: got %b want 1", rd_gnt); end
        @(negedge clk);
        reset = 1'b1; idle_inputs(); vga_req = 1'b1; vga_addr = 17'h00050;
        #1;
        total++; if (vga_gnt !== 1'b0) begin bad++; $display("FAIL mid_forced_gnt: got %b want 0", vga_gnt); end
        @(negedge clk);
        reset = 1'b0; idle_inputs();
        rd_req = 1'b1; rd_addr = 17'h00060; wr_req = 1'b1; wr_addr = 17'h00061; wr_data = 8'h44;
        #1;
        total++; if (rd_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid_n2: got %b want 0", rd_rvalid); end
        total++; if (conflict_cnt !== 16'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", conflict_cnt); end
        total++; if ({rd_gnt, wr_gnt} !== 2'b10) begin bad++; $display("FAIL mid_ptr: got %b want 10", {rd_gnt, wr_gnt}); end
        @(negedge clk);
        idle_inputs(); #1;
        total++; if (rd_rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid_n3: got %b want 0", rd_rvalid); end
        @(negedge clk); #1;
        $display("txn reset_mid_read post-reset read rd_rvalid=%b rdata=%h", rd_rvalid, rdata);
        total++; if ({rd_rvalid, rdata} !== {1'b1, 8'h5C}) begin bad++; $display("FAIL mid_new_read: got rvalid=%b rdata=%h want 1/5c", rd_rvalid, rdata); end
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = 8'(a) ^ 8'h3C;
        idle_inputs();
        scl_en = 1'b0;
        reset = 1'b1;
        test_reset();
        test_vga_only();
        test_back_to_back();
        test_contention();
        test_round_robin();
        test_gating();
        test_coherency();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17, frame-buffer word address width (320x240 = 76800 words).
REQ-002 Parameter DATA_W, default 8, pixel width.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 vga_req  in  1  display read request (port V); vga_addr  in  ADDR_W  its address.
REQ-006 vga_gnt  out  1  combinational grant to V; vga_rvalid  out  1  read-data strobe to V.
REQ-007 scl_en  in  1  scaler session active (driven from the zoom controller's enable); gates ports R and W.
REQ-008 rd_req  in  1  scaler read request (port R); rd_addr  in  ADDR_W; rd_gnt  out  1; rd_rvalid  out  1.
REQ-009 wr_req  in  1  scaler write request (port W); wr_addr  in  ADDR_W; wr_data  in  DATA_W; wr_gnt  out  1.
REQ-010 rdata  out  DATA_W  shared read-data bus, valid only with vga_rvalid or rd_rvalid.
REQ-011 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_wren  out  1; mem_rdata  in  DATA_W  -- single-port RAM, registered address, one-cycle read latency.
REQ-012 conflict_cnt  out  16  count of cycles in which any scaler request was denied.

Function
REQ-013 At most one grant SHALL be asserted per cycle; grants are combinational from current requests and state.
REQ-014 V SHALL have absolute priority: vga_req=1 -> vga_gnt=1, rd_gnt=0, wr_gnt=0 in that cycle.
REQ-015 R and W SHALL be eligible only when scl_en=1; with scl_en=0 their requests are ignored and not counted.
REQ-016 Between eligible R and W with V idle, a 1-bit round-robin pointer SHALL pick the winner; pointer points to R after reset.
REQ-017 Pointer SHALL toggle to the other scaler port only in a cycle where a scaler port is granted; a V grant leaves it unchanged.
REQ-018 If only one of R/W requests (V idle), it SHALL be granted regardless of pointer, and the pointer moves to the other port.
REQ-019 Requesters SHALL hold req and address stable until the grant cycle; a grant consumes exactly one request per cycle; back-to-back grants to one port are legal.
REQ-020 In the cycle after a grant, mem_addr SHALL equal the granted address; mem_wren=1 and mem_wdata=wr_data only for a W grant; otherwise mem_wren=0 and mem_addr/mem_wdata hold last value.
REQ-021 Read return: a V or R grant in cycle N SHALL produce vga_rvalid or rd_rvalid respectively in cycle N+2 with rdata=mem_rdata; a 2-stage tag pipeline (valid + owner) tracks it.
REQ-022 Reads SHALL be pipelined: one read grant per cycle sustains one rvalid per cycle, in grant order.
REQ-023 Falling scl_en SHALL not cancel R reads already granted; their rd_rvalid still issues.
REQ-024 conflict_cnt SHALL increment by 1 in each cycle where (eligible rd_req or wr_req) and that port is not granted (one increment per cycle even if both denied), saturating at 16'hFFFF.
REQ-025 Write-then-read to same address granted in consecutive cycles SHALL return the new data (RAM write-first order guaranteed by issue order).

Reset
REQ-026 On reset: all grants 0 (combinational, forced while reset=1), vga_rvalid=0, rd_rvalid=0, mem_wren=0, mem_addr=0, mem_wdata=0, conflict_cnt=0, tag pipeline cleared, pointer=R.
REQ-027 Reset mid-operation SHALL discard in-flight read tags: no rvalid in the two cycles after reset even if grants preceded it.

Verification
REQ-028 V only: vga_req=1, vga_addr=0x00010 at cycle N -> vga_gnt=1 at N, mem_addr=0x00010 at N+1, vga_rvalid=1 with rdata=RAM[0x10] at N+2.
REQ-029 Contention: vga_req, rd_req, wr_req all 1, scl_en=1 for 3 cycles -> vga_gnt each cycle, rd_gnt=wr_gnt=0, conflict_cnt=3, pointer still R.
REQ-030 Round-robin: scl_en=1, rd_req=wr_req=1 continuously, V idle -> grants R,W,R,W...; mem_wren=1 on every second cycle after the first W grant.
REQ-031 Gating: scl_en=0, rd_req=wr_req=1 for 10 cycles -> no scaler grants, mem_wren=0, conflict_cnt stays 0.
REQ-032 Coherency: W grant addr 0x12C00 data 0xA5 at N, R grant same addr at N+1 -> rd_rvalid at N+3 with rdata=0xA5.
REQ-033 Reset mid-read: R granted at N, reset=1 at N+1 -> rd_rvalid=0 at N+2 and N+3; conflict_cnt=0; next simultaneous R/W request grants R first.
